// File: rtl/apb_master.sv
// Single-transfer APB3 master: turns the bridge's flat read/write request into
// a SETUP/ACCESS sequence, with a wait-state timeout so a hung slave cannot stall the core.
module apb_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            m_apb_pclk_i,
    input  logic            m_apb_preset_i,

    input  logic [AW-1:0]   read_write_addr_i,
    input  logic [NSLV-1:0] read_write_sel_i,
    input  logic            write_en_i,
    input  logic [DW-1:0]   write_data_i,
    input  logic            read_en_i,
    output logic [DW-1:0]   read_data_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,

    output logic [AW-1:0]   m_apb_paddr_o,
    output logic [NSLV-1:0] m_apb_psel_o,
    output logic            m_apb_penable_o,
    output logic            m_apb_pwrite_o,
    output logic [DW-1:0]   m_apb_pwdata_o,
    output logic [2:0]      m_apb_pprot_o,
    input  logic [DW-1:0]   m_apb_prdata_i,
    input  logic            m_apb_pready_i,
    input  logic            m_apb_pslverr_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]      state;
    logic [7:0]      wait_cnt;
    logic [NSLV-1:0] sel_first;
    logic            accept;
    logic            timed_out;

    // Lowest set select bit wins, so the registered psel is always one-hot.
    always_comb begin
        // NOTE: default assignment first so no latch is inferred on paths that skip the loop body.
        sel_first = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (read_write_sel_i[i]) begin
                sel_first    = '0;
                sel_first[i] = 1'b1;
            end
        end
    end

    assign accept    = (state == ST_IDLE) && (write_en_i || read_en_i);
    assign timed_out = !m_apb_pready_i && (wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge m_apb_pclk_i or posedge m_apb_preset_i) begin
        if (m_apb_preset_i) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            m_apb_paddr_o   <= '0;
            m_apb_psel_o    <= '0;
            m_apb_penable_o <= 1'b0;
            m_apb_pwrite_o  <= 1'b0;
            m_apb_pwdata_o  <= '0;
            read_data_o     <= '0;
            done_o          <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every flop samples pre-edge values.
            done_o  <= 1'b0;
            error_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        m_apb_paddr_o  <= read_write_addr_i;
                        m_apb_pwdata_o <= write_data_i;
                        m_apb_pwrite_o <= write_en_i;
                        if (|read_write_sel_i) begin
                            m_apb_psel_o <= sel_first;
                            state        <= ST_SETUP;
                        end else begin
                            // No slave addressed: finish immediately as an error, no bus cycle.
                            done_o      <= 1'b1;
                            error_o     <= 1'b1;
                            read_data_o <= '0;
                        end
                    end
                end

                ST_SETUP: begin
                    m_apb_penable_o <= 1'b1;
                    wait_cnt        <= '0;
                    state           <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (m_apb_pready_i) begin
                        state           <= ST_IDLE;
                        m_apb_psel_o    <= '0;
                        m_apb_penable_o <= 1'b0;
                        done_o          <= 1'b1;
                        error_o         <= m_apb_pslverr_i;
                        if (!m_apb_pwrite_o) begin
                            read_data_o <= m_apb_pslverr_i ? '0 : m_apb_prdata_i;
                        end
                    end else if (timed_out) begin
                        state           <= ST_IDLE;
                        m_apb_psel_o    <= '0;
                        m_apb_penable_o <= 1'b0;
                        done_o          <= 1'b1;
                        error_o         <= 1'b1;
                        read_data_o     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    m_apb_psel_o    <= '0;
                    m_apb_penable_o <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = (state != ST_IDLE);
    assign m_apb_pprot_o = 3'b000;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a behavioural slave answers ACCESS cycles, and
// every expected completion (error, read data, cycle of done) is queued at request time.
module tb_apb_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NSLV = 4;
    localparam int TMO  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   addr;
    logic [NSLV-1:0] sel;
    logic            we;
    logic [DW-1:0]   wdata;
    logic            re;
    logic [DW-1:0]   rdata;
    logic            busy, done, error;
    logic [AW-1:0]   paddr;
    logic [NSLV-1:0] psel;
    logic            penable, pwrite;
    logic [DW-1:0]   pwdata;
    logic [2:0]      pprot;
    logic [DW-1:0]   prdata;
    logic            pready, pslverr;

    apb_master #(.AW(AW), .DW(DW), .NSLV(NSLV), .TIMEOUT(TMO)) dut (
        .m_apb_pclk_i      (clk),
        .m_apb_preset_i    (rst),
        .read_write_addr_i (addr),
        .read_write_sel_i  (sel),
        .write_en_i        (we),
        .write_data_i      (wdata),
        .read_en_i         (re),
        .read_data_o       (rdata),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (error),
        .m_apb_paddr_o     (paddr),
        .m_apb_psel_o      (psel),
        .m_apb_penable_o   (penable),
        .m_apb_pwrite_o    (pwrite),
        .m_apb_pwdata_o    (pwdata),
        .m_apb_pprot_o     (pprot),
        .m_apb_prdata_i    (prdata),
        .m_apb_pready_i    (pready),
        .m_apb_pslverr_i   (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        int            exp_cycle;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    exp_t          new_e;
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc      = 0;
    int            n_done   = 0;
    int            n_pushed = 0;
    logic [DW-1:0] model_rdata = '0;

    // Slave behaviour for the transfer currently in flight.
    int            slv_wait  = 0;
    logic          slv_hang  = 1'b0;
    logic          slv_err   = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    int            acc_n     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: pready rises on ACCESS cycle number slv_wait (0-based) unless hung.
    always @(negedge clk) begin
        if (psel != '0 && penable) begin
            pready  = !slv_hang && (acc_n == slv_wait);
            pslverr = slv_err;
            prdata  = slv_rdata;
            acc_n   = acc_n + 1;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = '0;
            acc_n   = 0;
        end
    end

    // Completion monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("t%0d_error", mon_e.id), 32'(error), 32'(mon_e.exp_err));
                check($sformatf("t%0d_rdata", mon_e.id), rdata, mon_e.exp_rdata);
                check($sformatf("t%0d_latency", mon_e.id), 32'(cyc), 32'(mon_e.exp_cycle));
            end
        end
    end

    // Called at a negedge; leaves the request up for exactly one rising edge.
    task automatic issue(input int id, input logic [NSLV-1:0] s, input logic [AW-1:0] a,
                         input logic w, input logic r, input logic [DW-1:0] wd,
                         input int waits, input logic hang, input logic err,
                         input logic [DW-1:0] rd);
        slv_wait  = waits;
        slv_hang  = hang;
        slv_err   = err;
        slv_rdata = rd;
        sel = s; addr = a; we = w; re = r; wdata = wd;
        new_e.id = id;
        if (s == '0) begin
            new_e.exp_cycle = cyc + 1;
            new_e.exp_err   = 1'b1;
            model_rdata     = '0;
        end else if (hang) begin
            new_e.exp_cycle = cyc + 3 + TMO;
            new_e.exp_err   = 1'b1;
            model_rdata     = '0;
        end else begin
            new_e.exp_cycle = cyc + 3 + waits;
            new_e.exp_err   = err;
            if (!w) model_rdata = err ? '0 : rd;
        end
        new_e.exp_rdata = model_rdata;
        sb.push_back(new_e);
        n_pushed++;
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
    endtask

    // Request with no expected completion (ignored or aborted by reset).
    task automatic drive_raw(input logic [NSLV-1:0] s, input logic [AW-1:0] a,
                             input logic w, input logic r);
        sel = s; addr = a; we = w; re = r; wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        addr = '0; sel = '0; we = 1'b0; re = 1'b0; wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (3) @(negedge clk);

        check("rst_psel",    32'(psel),    32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite",  32'(pwrite),  32'd0);
        check("rst_paddr",   paddr,        32'd0);
        check("rst_pwdata",  pwdata,       32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_error",   32'(error),   32'd0);
        check("rst_pprot",   32'(pprot),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read, zero wait states.
        issue(1, 4'b0010, 32'h0000_0010, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("t1_setup_psel",    32'(psel),    32'b0010);
        check("t1_setup_penable", 32'(penable), 32'd0);
        check("t1_setup_paddr",   paddr,        32'h0000_0010);
        check("t1_setup_pwrite",  32'(pwrite),  32'd0);
        check("t1_setup_busy",    32'(busy),    32'd1);
        @(negedge clk);
        check("t1_access_psel",    32'(psel),    32'b0010);
        check("t1_access_penable", 32'(penable), 32'd1);
        drain("t1_drain");
        check("t1_psel_after", 32'(psel), 32'd0);

        // Write with three wait states; read data must keep 0xDEADBEEF.
        issue(2, 4'b0001, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_00A5, 3, 1'b0, 1'b0, 32'h1111_1111);
        check("t2_setup_pwrite", 32'(pwrite), 32'd1);
        check("t2_setup_pwdata", pwdata,      32'h0000_00A5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t2_acc%0d_penable", i), 32'(penable), 32'd1);
            check($sformatf("t2_acc%0d_pwdata", i),  pwdata,       32'h0000_00A5);
            check($sformatf("t2_acc%0d_pwrite", i),  32'(pwrite),  32'd1);
        end
        drain("t2_drain");

        // Slave never ready: timeout error.
        issue(3, 4'b0100, 32'h0000_0030, 1'b0, 1'b1, '0, 0, 1'b1, 1'b0, 32'h2222_2222);
        drain("t3_drain");
        check("t3_psel_after", 32'(psel), 32'd0);
        check("t3_busy_after", 32'(busy), 32'd0);
        slv_hang = 1'b0;

        // Good read, then a no-slave request which must clear read data.
        issue(4, 4'b1000, 32'h0000_0040, 1'b0, 1'b1, '0, 1, 1'b0, 1'b0, 32'hC0FF_EE01);
        drain("t4_drain");
        issue(5, 4'b0000, 32'h0000_0050, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 32'h3333_3333);
        check("t5_psel", 32'(psel), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        drain("t5_drain");

        // Good read, then a read answered with PSLVERR.
        issue(6, 4'b0100, 32'h0000_0060, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 32'h5555_AAAA);
        drain("t6_drain");
        issue(7, 4'b0100, 32'h0000_0070, 1'b0, 1'b1, '0, 2, 1'b0, 1'b1, 32'h1234_5678);
        drain("t7_drain");

        // Multiple select bits: lowest index wins.
        issue(8, 4'b0110, 32'h0000_0080, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 32'h8888_0001);
        check("t8_psel_onehot", 32'(psel), 32'b0010);
        drain("t8_drain");

        // Request while busy is ignored.
        issue(9, 4'b0001, 32'h0000_0090, 1'b0, 1'b1, '0, 1, 1'b0, 1'b0, 32'h9999_0009);
        drive_raw(4'b1000, 32'h0000_0099, 1'b1, 1'b0);
        check("t9_psel_kept",   32'(psel),   32'b0001);
        check("t9_pwrite_kept", 32'(pwrite), 32'd0);
        check("t9_paddr_kept",  paddr,       32'h0000_0090);
        drain("t9_drain");
        repeat (4) @(negedge clk);

        // Request on the done cycle is accepted straight away.
        issue(10, 4'b0010, 32'h0000_00A0, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0, 32'h1111_2222);
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t10_done_seen", 32'(done), 32'd1);
        issue(11, 4'b0100, 32'h0000_00B0, 1'b1, 1'b0, 32'h0000_0077, 0, 1'b0, 1'b0, '0);
        check("t11_setup_busy",    32'(busy),    32'd1);
        check("t11_setup_psel",    32'(psel),    32'b0100);
        check("t11_setup_penable", 32'(penable), 32'd0);
        check("t11_setup_pwrite",  32'(pwrite),  32'd1);
        drain("t11_drain");

        // Both enables high: write wins, read data unchanged.
        issue(12, 4'b0001, 32'h0000_00C0, 1'b1, 1'b1, 32'hBEEF_0001, 0, 1'b0, 1'b0, 32'h9999_9999);
        check("t12_pwrite", 32'(pwrite), 32'd1);
        check("t12_pwdata", pwdata,      32'hBEEF_0001);
        drain("t12_drain");

        // Asynchronous reset in ACCESS: outputs drop at once, no done follows.
        slv_hang = 1'b1;
        drive_raw(4'b0010, 32'h0000_00D0, 1'b0, 1'b1);
        @(negedge clk);
        check("t13_in_access", 32'(penable), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t13_rst_psel",    32'(psel),    32'd0);
        check("t13_rst_penable", 32'(penable), 32'd0);
        check("t13_rst_busy",    32'(busy),    32'd0);
        check("t13_rst_done",    32'(done),    32'd0);
        check("t13_rst_rdata",   rdata,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        slv_hang = 1'b0;
        repeat (8) @(negedge clk);

        check("final_done_count", 32'(n_done), 32'(n_pushed));
        check("final_sb_empty",   32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-clock APB3 master that sits directly downstream of the memory-to-APB bridge. It takes the bridge's flat request signals (address, slave select, read/write enables, write data), sequences them into a standard APB SETUP/ACCESS transfer towards the peripheral slaves, and returns read data plus `busy`/`done` status. One transfer is in flight at a time. A wait-state timeout guarantees that a hung slave cannot stall the core.

## Interface
- `AW`, 32, APB address width (matches `APB_AW`)
- `DW`, 32, APB data width (matches `APB_DW`)
- `NSLV`, 4, number of APB slaves (matches `APB_SLAVES`)
- `TIMEOUT`, 255, maximum ACCESS wait states before forced error termination (1..255)
- `m_apb_pclk_i` in 1: the single clock; all logic is on its rising edge
- `m_apb_preset_i` in 1: reset, asynchronous and active-high
- `read_write_addr_i` in AW: request address
- `read_write_sel_i` in NSLV: one-hot slave select
- `write_en_i` in 1: write request
- `write_data_i` in DW: write data
- `read_en_i` in 1: read request
- `read_data_o` out DW: read data, valid while `done_o`=1 and held until the next completion
- `busy_o` out 1: transfer in progress
- `done_o` out 1: one-cycle completion pulse
- `error_o` out 1: qualifies `done_o`; set on PSLVERR, timeout, or no-slave
- `m_apb_paddr_o` out AW, `m_apb_psel_o` out NSLV, `m_apb_penable_o` out 1, `m_apb_pwrite_o` out 1, `m_apb_pwdata_o` out DW, `m_apb_pprot_o` out 3: APB request signals
- `m_apb_prdata_i` in DW, `m_apb_pready_i` in 1, `m_apb_pslverr_i` in 1: APB response signals

## Operation
- **States:** IDLE, SETUP, ACCESS. `busy_o` = (state != IDLE).
- **Accept.**
  - In IDLE, a request is accepted when `write_en_i | read_en_i` is 1.
  - On acceptance, the block registers address, write data, direction and select.
  - If both enables are high, the transfer is a write and the read is dropped.
  - Requests presented while `busy_o`=1 are ignored. Upstream holds or reissues them.
- **Select decode.**
  - If more than one select bit is set, the lowest set index wins. The registered `psel` is strictly one-hot.
  - If `read_write_sel_i`==0 on accept:
    - no APB cycle is issued;
    - state stays IDLE;
    - the next cycle gives `done_o`=1, `error_o`=1, `read_data_o`=0.
- **SETUP** (one cycle): `psel`=1 at the selected index, `penable`=0, `paddr`/`pwrite`/`pwdata` driven from the registers. The next state is always ACCESS.
- **ACCESS:** `psel`=1, `penable`=1. The block waits for `pready`=1.
  - **On `pready`:**
    - go to IDLE and drop `psel`/`penable`;
    - pulse `done_o`;
    - `error_o` = `pslverr`;
    - for a read with no error, `read_data_o` = `prdata`; for an errored read, `read_data_o` = 0;
    - for a write, `read_data_o` is unchanged.
  - **Timeout:**
    - A wait counter (8 bit) clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
    - When the counter equals TIMEOUT and `pready`=0, the transfer completes as an error: IDLE, `done_o`=1, `error_o`=1, read data 0.
    - A `pready` arriving in that same cycle takes priority and completes normally.
- `m_apb_pprot_o` is always 3'b000.
- `paddr`, `pwrite` and `pwdata` hold their values after completion. `paddr` is only meaningful while `psel`=1.

## Timing
- **Reset:**
  - state IDLE;
  - `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0;
  - `read_data_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0, wait counter 0.
- **Reset mid-transfer:** all outputs go to their reset values immediately (asynchronous). No `done_o` is produced for the aborted transfer.
- **Zero-wait transfer:**
  - request sampled at edge E0;
  - SETUP during E0–E1;
  - ACCESS during E1–E2, with `pready` sampled at E2;
  - `done_o` high during E2–E3, with state already IDLE.
  - A new request sampled at E3 is accepted. Peak throughput is one transfer per 3 cycles.
- Each wait state adds exactly 1 cycle. A timed-out transfer lasts 3+TIMEOUT cycles from accept to `done_o`.
- `done_o` and `error_o` are registered outputs, high for exactly one cycle per accepted request.
- `busy_o` falls in the same cycle that `done_o` rises.
- Request outputs are all registered; there is no combinational path from any input to an APB output.

## Test plan
- **Read, zero wait:** sel=4'b0010, addr 0x0000_0010, `read_en`=1 for one cycle; slave returns `pready`=1, `prdata`=0xDEAD_BEEF → `psel`=4'b0010 for 2 cycles, `penable` high in the 2nd, `done_o` 3 cycles after the request with `read_data_o`=0xDEAD_BEEF and `error_o`=0.
- **Write with 3 wait states:** sel=4'b0001, data 0x0000_00A5 → `pwrite`=1, `pwdata`=0xA5 stable through ACCESS, `done_o` 6 cycles after the request; `read_data_o` keeps its previous value.
- **Timeout:** TIMEOUT=4, slave never asserts `pready` → `done_o`/`error_o` 7 cycles after the request, `read_data_o`=0, `psel` low afterwards.
- **Error and decode corner cases:**
  - `pslverr`=1 with `pready` on a read → `error_o`=1, `read_data_o`=0.
  - sel=0 → `done_o`/`error_o` the next cycle with no `psel` activity.
  - sel=4'b0110 → only `psel[1]` is asserted.
- **Back-to-back and simultaneous events:**
  - A request issued while `busy_o`=1 → ignored.
  - A request on the `done_o` cycle → accepted, with SETUP on the next cycle.
  - Write and read enables both high → a write is performed.
- **Reset during ACCESS:** assert `m_apb_preset_i` asynchronously → `psel`/`penable`/`busy_o` drop within the same cycle, and no `done_o` follows.
